// File: rtl/cache_victim_writeback.sv
// cache_victim_writeback: queues evicted dirty lines and drains them to the bus beat by beat,
// forwarding still-pending lines to refills of the same line address.
module cache_victim_writeback #(
    parameter int NUMENTRIES = 4,
    parameter int LINELEN    = 512,
    parameter int BEATLEN    = 64,
    parameter int PA_BITS    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          VictimValid,
    output logic                          VictimReady,
    input  logic [PA_BITS-1:0]            VictimAdr,
    input  logic [LINELEN-1:0]            VictimLine,
    input  logic [PA_BITS-1:0]            LookupAdr,
    output logic                          LookupHit,
    output logic [LINELEN-1:0]            LookupLine,
    output logic                          BusValid,
    input  logic                          BusReady,
    output logic [PA_BITS-1:0]            BusAdr,
    output logic [BEATLEN-1:0]            BusWData,
    output logic                          BusLast,
    output logic                          Empty,
    output logic [$clog2(NUMENTRIES):0]   Count
);
    localparam int BEATS = LINELEN / BEATLEN;
    localparam int PW = $clog2(NUMENTRIES);
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int CW = PW + 1;
    localparam logic [PA_BITS-1:0] OFF_MASK = PA_BITS'(LINELEN / 8 - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t               state, state_n;
    logic [PA_BITS-1:0]   adr_q  [NUMENTRIES];
    logic [LINELEN-1:0]   line_q [NUMENTRIES];
    logic [NUMENTRIES-1:0] vld;
    logic [PW-1:0]        head, tail, idx;
    logic [BW-1:0]        b;
    logic                 push, pop;

    // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
    assign VictimReady = Count != CW'(NUMENTRIES);
    assign push        = VictimValid & VictimReady;
    assign pop         = BusValid & BusReady & BusLast;
    assign Empty       = Count == '0;
    assign BusAdr      = adr_q[head] + PA_BITS'(b) * PA_BITS'(BEATLEN / 8);
    assign BusWData    = line_q[head][b * BEATLEN +: BEATLEN];
    assign BusLast     = BusValid & (b == BW'(BEATS - 1));

    always_comb begin
        BusValid = state == BURST;
        state_n  = state == IDLE ? ((push || Count != '0) ? BURST : IDLE)
                                 : ((pop && !push && Count == CW'(1)) ? IDLE : BURST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            head  <= '0;
            tail  <= '0;
            b     <= '0;
            Count <= '0;
            vld   <= '0;
        end else begin
            state <= state_n;
            Count <= Count + CW'(push) - CW'(pop);
            b     <= (BusValid & BusReady) ? (BusLast ? '0 : b + BW'(1)) : b;
            if (push) begin
                vld[tail] <= 1'b1;
                tail      <= tail + PW'(1);
            end
            if (pop) begin
                vld[head] <= 1'b0;
                head      <= head + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            adr_q[tail]  <= VictimAdr;
            line_q[tail] <= VictimLine;
        end
    end

    // Walk from head towards tail so the youngest matching entry is the one left standing.
    always_comb begin
        LookupHit  = 1'b0;
        LookupLine = '0;
        idx        = '0;
        for (int i = 0; i < NUMENTRIES; i++) begin
            idx = head + PW'(i);
            if (vld[idx] && ((adr_q[idx] ^ LookupAdr) & ~OFF_MASK) == '0) begin
                LookupHit  = 1'b1;
                LookupLine = line_q[idx];
            end
        end
    end
endmodule

// File: tb/tb_cache_victim_writeback.sv
// tb_cache_victim_writeback: randomized and directed stimulus checked against a queue-based model
// of the victim buffer (FIFO of lines, beat index into the head line, youngest-match lookup).
module tb_cache_victim_writeback;
    localparam int N = 4, LL = 512, BL = 64, PA = 32, BEATS = LL / BL;

    logic            clk = 1'b0, reset;
    logic            VictimValid, VictimReady, LookupHit, BusValid, BusReady, BusLast, Empty;
    logic [PA-1:0]   VictimAdr, LookupAdr, BusAdr;
    logic [LL-1:0]   VictimLine, LookupLine;
    logic [BL-1:0]   BusWData;
    logic [2:0]      Count;

    typedef struct {
        logic [PA-1:0] adr;
        logic [LL-1:0] line;
    } ent_t;

    ent_t q[$];
    int   mb = 0;
    int   checks = 0, errors = 0;

    cache_victim_writeback #(.NUMENTRIES(N), .LINELEN(LL), .BEATLEN(BL), .PA_BITS(PA)) dut (
        .clk(clk), .reset(reset),
        .VictimValid(VictimValid), .VictimReady(VictimReady), .VictimAdr(VictimAdr), .VictimLine(VictimLine),
        .LookupAdr(LookupAdr), .LookupHit(LookupHit), .LookupLine(LookupLine),
        .BusValid(BusValid), .BusReady(BusReady), .BusAdr(BusAdr), .BusWData(BusWData), .BusLast(BusLast),
        .Empty(Empty), .Count(Count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LL-1:0] got, input logic [LL-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit vv, input bit br, input logic [PA-1:0] a, input logic [PA-1:0] la);
        VictimValid = vv;
        BusReady    = br;
        VictimAdr   = a;
        LookupAdr   = la;
        for (int i = 0; i < LL / 32; i++) VictimLine[i*32 +: 32] = $urandom();
    endtask

    // Check all outputs against the model, then advance the model across the next rising edge.
    task automatic step();
        logic [LL-1:0] el;
        bit hit, push, pop;
        #1;
        chk("count", Count, q.size());
        chk("empty", Empty, q.size() == 0);
        chk("victim_ready", VictimReady, q.size() != N);
        chk("bus_valid", BusValid, q.size() != 0);
        if (q.size() != 0) begin
            chk("bus_adr", BusAdr, q[0].adr + mb * (BL / 8));
            chk("bus_wdata", BusWData, q[0].line[mb*BL +: BL]);
            chk("bus_last", BusLast, mb == BEATS - 1);
        end else chk("bus_last_idle", BusLast, 0);
        hit = 0;
        el  = '0;
        foreach (q[i]) if ((q[i].adr >> 6) == (LookupAdr >> 6)) begin
            hit = 1;
            el  = q[i].line;
        end
        chk("lookup_hit", LookupHit, hit);
        if (hit) chk("lookup_line", LookupLine, el);
        push = VictimValid && q.size() != N;
        pop  = q.size() != 0 && BusReady;
        @(posedge clk);
        if (pop) begin
            if (mb == BEATS - 1) begin
                void'(q.pop_front());
                mb = 0;
            end else mb++;
        end
        if (push) q.push_back('{adr: VictimAdr, line: VictimLine});
    endtask

    task automatic cyc(input bit vv, input bit br, input logic [PA-1:0] a, input logic [PA-1:0] la);
        @(negedge clk);
        drive(vv, br, a, la);
        step();
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, '0, '0);
        repeat (2) @(negedge clk);
        step();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) cyc(0, 1, '0, 32'h8000_0040);

        // Single line with patterned beats, bus always ready.
        @(negedge clk);
        drive(1, 1, 32'h8000_0040, 32'h8000_0040);
        for (int k = 0; k < BEATS; k++) VictimLine[k*BL +: BL] = 64'h1111_0000_0000_0000 * k;
        step();
        repeat (11) cyc(0, 1, '0, 32'h8000_0040);

        // Fill while stalled, attempt a fifth push, then drain back to back.
        for (int i = 0; i < 6; i++) cyc(1, 0, 32'h0000_2000 + i * 64, 32'h0000_2040);
        repeat (36) cyc(0, 1, '0, 32'h0000_20c0);

        // Duplicate address: youngest wins, then both drain away.
        cyc(1, 0, 32'h0000_1000, 32'h0000_1020);
        cyc(1, 0, 32'h0000_1000, 32'h0000_1020);
        repeat (3) cyc(0, 0, '0, 32'h0000_1020);
        repeat (20) cyc(0, 1, '0, 32'h0000_1020);

        // Async reset mid-burst on a two-entry queue.
        cyc(1, 0, 32'h0000_3000, 32'h0000_3000);
        cyc(1, 0, 32'h0000_3040, 32'h0000_3000);
        repeat (3) cyc(0, 1, '0, 32'h0000_3000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_bus_valid", BusValid, 0);
        chk("rst_count", Count, 0);
        chk("rst_lookup_hit", LookupHit, 0);
        q.delete();
        mb = 0;
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1, '0, 32'h0000_3000);
        step();
        repeat (5) cyc(0, 1, '0, 32'h0000_3040);

        // Random traffic over a small address pool to force duplicates and lookup hits.
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0,
                32'h8000_0000 + ($urandom_range(0, 5) << 6),
                32'h8000_0000 + ($urandom_range(0, 6) << 6) + $urandom_range(0, 63));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
